// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch mode controller.
package stopwatch_pkg;

  // Controller state; all four codes are legal and used.
  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2,
    LAP   = 2'd3
  } state_e;

  // One resolved button event per cycle after priority arbitration.
  typedef enum logic [1:0] {
    EV_NONE    = 2'd0,
    EV_RUNSTOP = 2'd1,
    EV_CLEAR   = 2'd2,
    EV_LAP     = 2'd3
  } event_e;

  // 10 ms of stable input at 100 MHz.
  localparam int DB_CYCLES_DEFAULT = 1_000_000;
  localparam int CNT_W_DEFAULT     = 20;

  // Priority runstop > clear > lap; losers in the same cycle are dropped.
  function automatic event_e pick_event(input logic rs, input logic clr, input logic lap);
    if (rs)       return EV_RUNSTOP;
    else if (clr) return EV_CLEAR;
    else if (lap) return EV_LAP;
    else          return EV_NONE;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizer, debounce counter and registered rising-edge pulse for one raw input.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q;
  logic             rise_q, rise_d;

  // Two-flop synchronizer for the asynchronous board input.
  // NOTE: sequential blocks use <= so every flop samples pre-edge values; = here would collapse the chain into one flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level; flip after DB_CYCLES of them.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missed branch would otherwise infer a latch.
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    rise_d = level_q & ~prev_q;
  end

  // Debounced level, edge history and registered press pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_q;
      rise_q  <= rise_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;

endmodule

// File: rtl/stopwatch_mode_ctrl.sv
// STOP/RUN/CLEAR/LAP controller driving the stopwatch datapath and display freeze.
module stopwatch_mode_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw0,
  input  logic       i_btn_runstop,
  input  logic       i_btn_clear,
  input  logic       i_btn_lap,
  output logic       o_runstop,
  output logic       o_clear,
  output logic       o_lap_hold,
  output logic       o_option,
  output logic [1:0] o_state
);

  logic   rs_rise, clr_rise, lap_rise;
  logic   rs_level_unused, clr_level_unused, lap_level_unused;
  logic   sw_level, sw_rise_unused;
  event_e evt_q, evt_d;
  state_e state_q, state_d;
  logic   runstop_q, runstop_d;
  logic   clear_q, clear_d;
  logic   hold_q, hold_d;
  logic   option_q, option_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_runstop (
    .clk(clk), .rst(rst), .i_raw(i_btn_runstop), .o_level(rs_level_unused), .o_rise(rs_rise)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_clear (
    .clk(clk), .rst(rst), .i_raw(i_btn_clear), .o_level(clr_level_unused), .o_rise(clr_rise)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_lap (
    .clk(clk), .rst(rst), .i_raw(i_btn_lap), .o_level(lap_level_unused), .o_rise(lap_rise)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_sw0 (
    .clk(clk), .rst(rst), .i_raw(sw0), .o_level(sw_level), .o_rise(sw_rise_unused)
  );

  // Arbitrate simultaneous presses into one event; the FSM consumes the registered copy.
  always_comb begin
    evt_d = pick_event(rs_rise, clr_rise, lap_rise);
  end

  // Next state plus Moore outputs decoded from it, so registered outputs line up with o_state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP: begin
        if (evt_q == EV_RUNSTOP)    state_d = RUN;
        else if (evt_q == EV_CLEAR) state_d = CLEAR;
      end
      RUN: begin
        if (evt_q == EV_RUNSTOP)  state_d = STOP;
        else if (evt_q == EV_LAP) state_d = LAP;
      end
      LAP: begin
        if (evt_q == EV_RUNSTOP)  state_d = STOP;
        else if (evt_q == EV_LAP) state_d = RUN;
      end
      CLEAR:   state_d = STOP;
      default: state_d = STOP;
    endcase

    runstop_d = (state_d == RUN) || (state_d == LAP);
    clear_d   = (state_d == CLEAR);
    hold_d    = (state_d == LAP);
    // The display option only follows the switch while the watch is not counting.
    option_d  = ((state_d == STOP) || (state_d == CLEAR)) ? sw_level : option_q;
  end

  // State, event and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= STOP;
      evt_q     <= EV_NONE;
      runstop_q <= 1'b0;
      clear_q   <= 1'b0;
      hold_q    <= 1'b0;
      option_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      evt_q     <= evt_d;
      runstop_q <= runstop_d;
      clear_q   <= clear_d;
      hold_q    <= hold_d;
      option_q  <= option_d;
    end
  end

  assign o_runstop  = runstop_q;
  assign o_clear    = clear_q;
  assign o_lap_hold = hold_q;
  assign o_option   = option_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// Directed bench for stopwatch_mode_ctrl with DB_CYCLES = 4.
module tb_stopwatch_mode_ctrl;

  localparam int DB = 4;
  localparam int LAT = DB + 4;  // first sampled-high edge to state/output change

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw0, btn_rs, btn_clr, btn_lap;
  logic       o_runstop, o_clear, o_lap_hold, o_option;
  logic [1:0] o_state;

  int vectors = 0;
  int miscompares = 0;

  stopwatch_mode_ctrl #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst_n), .sw0(sw0),
    .i_btn_runstop(btn_rs), .i_btn_clear(btn_clr), .i_btn_lap(btn_lap),
    .o_runstop(o_runstop), .o_clear(o_clear), .o_lap_hold(o_lap_hold),
    .o_option(o_option), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are observed on the falling edge.
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full clean press: hold 10 cycles, release, wait for the release to debounce.
  task automatic press_rs();
    btn_rs = 1'b1; settle(10); btn_rs = 1'b0; settle(12);
  endtask

  task automatic press_lap();
    btn_lap = 1'b1; settle(10); btn_lap = 1'b0; settle(12);
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({o_state, o_runstop, o_clear, o_lap_hold, o_option} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_async: state=%0d rs=%b clr=%b hold=%b opt=%b, expected all 0",
               o_state, o_runstop, o_clear, o_lap_hold, o_option);
    end
    settle(3);
    vectors++;
    if ({o_state, o_runstop, o_clear, o_lap_hold, o_option} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_held: state=%0d rs=%b clr=%b hold=%b opt=%b, expected all 0",
               o_state, o_runstop, o_clear, o_lap_hold, o_option);
    end
    rst_n = 1'b1;
    settle(3);
  endtask

  task automatic test_runstop();
    btn_rs = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if (o_runstop !== (k >= LAT) || o_state !== ((k >= LAT) ? 2'd1 : 2'd0)) begin
        miscompares++;
        $display("FAIL run_latency k=%0d: rs=%b state=%0d, expected rs=%b state=%0d",
                 k, o_runstop, o_state, k >= LAT, (k >= LAT) ? 1 : 0);
      end
    end
    btn_rs = 1'b0;
    settle(12);
    btn_rs = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if (o_runstop !== (k < LAT) || o_state !== ((k >= LAT) ? 2'd0 : 2'd1)) begin
        miscompares++;
        $display("FAIL stop_latency k=%0d: rs=%b state=%0d, expected rs=%b state=%0d",
                 k, o_runstop, o_state, k < LAT, (k >= LAT) ? 0 : 1);
      end
    end
    btn_rs = 1'b0;
    settle(12);
  endtask

  task automatic test_clear();
    btn_clr = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      vectors++;
      if (o_clear !== (k == LAT) || o_state !== ((k == LAT) ? 2'd2 : 2'd0)) begin
        miscompares++;
        $display("FAIL clear_pulse k=%0d: clr=%b state=%0d, expected clr=%b state=%0d",
                 k, o_clear, o_state, k == LAT, (k == LAT) ? 2 : 0);
      end
      if (k == 9) btn_clr = 1'b0;
    end
    settle(8);
    // A glitch one sample shorter than the debounce window must be ignored.
    btn_clr = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 2) btn_clr = 1'b0;
      vectors++;
      if (o_clear !== 1'b0 || o_state !== 2'd0) begin
        miscompares++;
        $display("FAIL clear_glitch k=%0d: clr=%b state=%0d, expected clr=0 state=0",
                 k, o_clear, o_state);
      end
    end
  endtask

  task automatic test_lap();
    press_rs();
    vectors++;
    if (o_state !== 2'd1) begin
      miscompares++;
      $display("FAIL lap_setup: state=%0d, expected 1", o_state);
    end
    btn_lap = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if (o_state !== ((k >= LAT) ? 2'd3 : 2'd1) || o_lap_hold !== (k >= LAT) || o_runstop !== 1'b1) begin
        miscompares++;
        $display("FAIL lap_enter k=%0d: state=%0d hold=%b rs=%b, expected state=%0d hold=%b rs=1",
                 k, o_state, o_lap_hold, o_runstop, (k >= LAT) ? 3 : 1, k >= LAT);
      end
    end
    btn_lap = 1'b0;
    settle(12);
    btn_lap = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if (o_state !== ((k >= LAT) ? 2'd1 : 2'd3) || o_lap_hold !== (k < LAT) || o_runstop !== 1'b1) begin
        miscompares++;
        $display("FAIL lap_exit k=%0d: state=%0d hold=%b rs=%b, expected state=%0d hold=%b rs=1",
                 k, o_state, o_lap_hold, o_runstop, (k >= LAT) ? 1 : 3, k < LAT);
      end
    end
    btn_lap = 1'b0;
    settle(12);
    press_lap();
    btn_rs = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if (o_state !== ((k >= LAT) ? 2'd0 : 2'd3) || o_lap_hold !== (k < LAT) || o_runstop !== (k < LAT)) begin
        miscompares++;
        $display("FAIL lap_stop k=%0d: state=%0d hold=%b rs=%b, expected state=%0d hold=%b rs=%b",
                 k, o_state, o_lap_hold, o_runstop, (k >= LAT) ? 0 : 3, k < LAT, k < LAT);
      end
    end
    btn_rs = 1'b0;
    settle(12);
  endtask

  task automatic test_priority();
    btn_rs  = 1'b1;
    btn_clr = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      vectors++;
      if (o_clear !== 1'b0 || o_state !== ((k >= LAT) ? 2'd1 : 2'd0)) begin
        miscompares++;
        $display("FAIL priority k=%0d: clr=%b state=%0d, expected clr=0 state=%0d",
                 k, o_clear, o_state, (k >= LAT) ? 1 : 0);
      end
      if (k == 9) begin
        btn_rs  = 1'b0;
        btn_clr = 1'b0;
      end
    end
    settle(10);
    press_rs();
    vectors++;
    if (o_state !== 2'd0) begin
      miscompares++;
      $display("FAIL priority_restore: state=%0d, expected 0", o_state);
    end
  endtask

  task automatic test_option();
    press_rs();
    sw0 = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      vectors++;
      if (o_option !== 1'b0 || o_state !== 2'd1) begin
        miscompares++;
        $display("FAIL option_frozen k=%0d: opt=%b state=%0d, expected opt=0 state=1",
                 k, o_option, o_state);
      end
    end
    btn_rs = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if (o_option !== (k >= LAT) || o_state !== ((k >= LAT) ? 2'd0 : 2'd1)) begin
        miscompares++;
        $display("FAIL option_apply k=%0d: opt=%b state=%0d, expected opt=%b state=%0d",
                 k, o_option, o_state, k >= LAT, (k >= LAT) ? 0 : 1);
      end
    end
    btn_rs = 1'b0;
    settle(12);
    sw0 = 1'b0;
    settle(12);
    vectors++;
    if (o_option !== 1'b0) begin
      miscompares++;
      $display("FAIL option_track_stop: opt=%b, expected 0", o_option);
    end
  endtask

  task automatic test_reset_mid();
    press_rs();
    btn_lap = 1'b1;
    settle(3);
    #2 rst_n = 1'b0;
    btn_lap = 1'b0;
    btn_rs  = 1'b1;
    #1;
    vectors++;
    if ({o_state, o_runstop, o_clear, o_lap_hold, o_option} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async: state=%0d rs=%b clr=%b hold=%b opt=%b, expected all 0",
               o_state, o_runstop, o_clear, o_lap_hold, o_option);
    end
    settle(3);
    vectors++;
    if ({o_state, o_runstop, o_clear, o_lap_hold, o_option} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_mid_held: state=%0d rs=%b clr=%b hold=%b opt=%b, expected all 0",
               o_state, o_runstop, o_clear, o_lap_hold, o_option);
    end
    // Button held through reset release is one press once debounced.
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vectors++;
      if (o_runstop !== (k >= LAT) || o_state !== ((k >= LAT) ? 2'd1 : 2'd0) || o_lap_hold !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_held_btn k=%0d: rs=%b state=%0d hold=%b, expected rs=%b state=%0d hold=0",
                 k, o_runstop, o_state, o_lap_hold, k >= LAT, (k >= LAT) ? 1 : 0);
      end
    end
    btn_rs = 1'b0;
    settle(12);
    press_rs();
    vectors++;
    if (o_state !== 2'd0 || o_runstop !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_final_stop: state=%0d rs=%b, expected state=0 rs=0", o_state, o_runstop);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    sw0     = 1'b0;
    btn_rs  = 1'b0;
    btn_clr = 1'b0;
    btn_lap = 1'b0;
    test_reset();
    test_runstop();
    test_clear();
    test_lap();
    test_priority();
    test_option();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
